// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg -- shared definitions for the multicycle MIPS CPU and its memory
// unit: opcode constants, the memory FSM state type, the word width and the
// latched request record.
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int WORD_W = 32;

    // Opcodes the CPU control FSM decodes.
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] J   = 6'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    // One memory request as seen at the CPU interface.
    typedef struct packed {
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
        logic [3:0]        be;
    } mem_req_t;

endpackage

// File: rtl/mips_mem_array.sv
// ---------------------------------------------------------------------------
// mips_mem_array -- synchronous single-port word RAM.
//   clock   : write and read-sample edge
//   reset_n : async active-low, clears only the read-data register
//   rd_en   : sample mem[idx] into rdata on this edge
//   wr_be   : per-byte write enables (bit i -> wdata[8i+7:8i])
//   idx     : word index
//   wdata   : write data
//   rdata   : registered read data, holds between reads
// ---------------------------------------------------------------------------
module mips_mem_array
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rd_en,
    input  logic [3:0]        wr_be,
    input  logic [AW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    // Storage itself is never reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   rdata_q <= '0;
        else if (rd_en) rdata_q <= mem[idx];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mips_mem_unit.sv
// ---------------------------------------------------------------------------
// mips_mem_unit -- word-addressed memory behind the multicycle MIPS control
// FSM. Accepts one request at a time, inserts WAIT_CYCLES wait states, then
// pulses rsp_valid for one cycle. Misaligned or out-of-range accesses
// respond with rsp_err=1, rsp_rdata=0 and never write.
//
// Ports:
//   clock, reset_n          : clock, async active-low reset
//   req_valid / req_ready   : request handshake (ready only in IDLE)
//   req_we                  : 1 = store, 0 = read
//   req_addr                : byte address
//   req_wdata, req_be       : store data and byte-lane enables
//   rsp_valid               : one-cycle response pulse
//   rsp_rdata, rsp_err      : response payload, held between responses
//
// Build option: define MIPS_MEM_BYTE_LANES_EN to make stores honour req_be;
// otherwise every store writes the full word.
// ---------------------------------------------------------------------------
module mips_mem_unit
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,   // power of two
    parameter int WAIT_CYCLES = 2       // 0..15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_LIM = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  WAIT_LIM = 4'(WAIT_CYCLES);

    mem_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    mem_req_t          req_q, req_d;
    mem_req_t          req_in, acc;
    logic              commit;
    logic              acc_err;
    logic              err_q;
    logic [3:0]        lanes;
    logic [WORD_W-1:0] arr_rdata;

    assign req_in = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

    // With no wait states the access commits on the accepting edge, before
    // req_q is loaded, so take the live request while still in IDLE.
    assign acc = (state_q == IDLE) ? req_in : req_q;

    assign acc_err = (acc.addr[1:0] != 2'b00) || ({1'b0, acc.addr} >= ADDR_LIM);

`ifdef MIPS_MEM_BYTE_LANES_EN
    assign lanes = acc.be;
`else
    // be is OR-ed in only so the field stays referenced; result is all lanes.
    assign lanes = acc.be | 4'hF;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    // WAIT lasts exactly WAIT_CYCLES cycles: the counter is loaded with 1 on
    // acceptance and RESP is entered on the edge where it equals WAIT_CYCLES.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d = req_in;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'd1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == WAIT_LIM) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Error flag is captured on the commit edge alongside the array read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    err_q <= 1'b0;
        else if (commit) err_q <= acc_err;
    end

    mips_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clock   (clock),
        .reset_n (reset_n),
        .rd_en   (commit && !acc.we && !acc_err),
        .wr_be   ((commit && acc.we && !acc_err) ? lanes : 4'h0),
        .idx     (acc.addr[AW+1:2]),
        .wdata   (acc.wdata),
        .rdata   (arr_rdata)
    );

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = err_q;
    assign rsp_rdata = err_q ? '0 : arr_rdata;

endmodule
